bcd_serial_sub: RTL and testbench

Digit-serial, multi-digit packed-BCD subtractor: computes D = A − B − bin one decimal digit per clock, least-significant digit first, with borrow propagated through a register. It is the subtraction counterpart of the team's one-digit combinational BCD adder. It sits beside the adder in the decimal arithmetic path, where area matters more than latency. Results that would go negative are returned in ten's-complement form with a borrow-out flag.

---
 rtl/bcd_serial_sub.sv | 116 +++++++++++
 tb/tb_bcd_serial_sub.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/bcd_serial_sub.sv
// Digit-serial packed-BCD subtractor: d = a - b - bin, one decimal digit per
// clock starting at digit 0. Negative results come back in ten's complement with bout=1.
module bcd_serial_sub #(
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [4*DIGITS-1:0]   a,
  input  logic [4*DIGITS-1:0]   b,
  input  logic                  bin,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   d,
  output logic                  bout,
  output logic                  err
);

  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [IW-1:0] LAST = IW'(DIGITS - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t                state;
  logic [IW-1:0]         idx;
  logic                  borrow;
  logic [4*DIGITS-1:0]   a_r;
  logic [4*DIGITS-1:0]   b_r;

  logic [4:0]            t;
  logic [3:0]            diff_digit;
  logic                  diff_borrow;
  logic                  start_ok;

  function automatic logic has_bad_digit(input logic [4*DIGITS-1:0] v);
    logic bad;
    bad = 1'b0;
    for (int k = 0; k < DIGITS; k++) begin
      if (v[4*k +: 4] > 4'd9) bad = 1'b1;
    end
    return bad;
  endfunction

  assign start_ok = (state == S_IDLE) && start;

  // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    t           = {1'b0, a_r[4*idx +: 4]} - {1'b0, b_r[4*idx +: 4]} - {4'b0, borrow};
    diff_borrow = t[4];
    diff_digit  = t[4] ? (t[3:0] + 4'd10) : t[3:0];
  end

  // NOTE: operand registers are plain data captured on every accepted start, so they carry no reset.
  always_ff @(posedge clk) begin
    if (start_ok) begin
      a_r <= a;
      b_r <= b;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      idx    <= '0;
      borrow <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
      d      <= '0;
      bout   <= 1'b0;
      err    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            idx    <= '0;
            borrow <= bin;
            busy   <= 1'b1;
            if (has_bad_digit(a) || has_bad_digit(b)) begin
              err   <= 1'b1;
              d     <= '0;
              bout  <= 1'b0;
              state <= S_DONE;
            end else begin
              err   <= 1'b0;
              state <= S_RUN;
            end
          end
        end
        S_RUN: begin
          d[4*idx +: 4] <= diff_digit;
          borrow        <= diff_borrow;
          idx           <= idx + 1'b1;
          if (idx == LAST) begin
            bout  <= diff_borrow;
            busy  <= 1'b0;
            state <= S_DONE;
          end
        end
        S_DONE: begin
          // start is deliberately not looked at here; it is picked up back in IDLE.
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_serial_sub.sv
// Self-checking bench for bcd_serial_sub: directed cases plus random sweeps on a
// 4-digit and a 1-digit instance, checked against a decimal-arithmetic model.
module tb_bcd_serial_sub;

  logic        clk = 1'b0;
  logic        rst_n;

  logic        start4, bin4, busy4, done4, bout4, err4;
  logic [15:0] a4, b4, d4;
  logic        start1, bin1, busy1, done1, bout1, err1;
  logic [3:0]  a1, b1, d1;

  int checks = 0;
  int passes = 0;

  always #5 clk = ~clk;

  bcd_serial_sub #(.DIGITS(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .a(a4), .b(b4), .bin(bin4),
    .busy(busy4), .done(done4), .d(d4), .bout(bout4), .err(err4)
  );

  bcd_serial_sub #(.DIGITS(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .a(a1), .b(b1), .bin(bin1),
    .busy(busy1), .done(done1), .d(d1), .bout(bout1), .err(err1)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Decimal reference: evaluate operands as integers, subtract, wrap mod 10^nd.
  task automatic model(input int nd, input logic [15:0] av, input logic [15:0] bv,
                       input logic bi, output logic [15:0] ed, output logic eb,
                       output logic ee);
    int va, vb, diff, modulus;
    logic [15:0] tmp;
    ee = 1'b0; va = 0; vb = 0; modulus = 1;
    for (int i = nd - 1; i >= 0; i--) begin
      if (av[4*i +: 4] > 9 || bv[4*i +: 4] > 9) ee = 1'b1;
      va = va * 10 + int'(av[4*i +: 4]);
      vb = vb * 10 + int'(bv[4*i +: 4]);
      modulus = modulus * 10;
    end
    ed = '0; eb = 1'b0;
    if (!ee) begin
      diff = va - vb - int'(bi);
      if (diff < 0) begin
        diff = diff + modulus;
        eb = 1'b1;
      end
      tmp = '0;
      for (int i = 0; i < nd; i++) begin
        tmp[4*i +: 4] = 4'(diff % 10);
        diff = diff / 10;
      end
      ed = tmp;
    end
  endtask

  function automatic logic [15:0] rand_bcd(input int nd);
    logic [15:0] v;
    v = '0;
    for (int i = 0; i < nd; i++) v[4*i +: 4] = 4'($urandom_range(0, 9));
    return v;
  endfunction

  function automatic logic obs_done(input int nd);
    return (nd == 4) ? done4 : done1;
  endfunction

  function automatic logic obs_busy(input int nd);
    return (nd == 4) ? busy4 : busy1;
  endfunction

  // Waits for done (bounded); returns the number of edges that elapsed.
  task automatic wait_done(input int nd, output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!obs_done(nd) && n < 40);
  endtask

  task automatic check_result(input string tag, input int nd, input logic [15:0] ed,
                              input logic eb, input logic ee);
    check({tag, "_d"},    (nd == 4) ? {16'b0, d4} : {28'b0, d1}, {16'b0, ed});
    check({tag, "_bout"}, (nd == 4) ? bout4 : bout1, eb);
    check({tag, "_err"},  (nd == 4) ? err4 : err1, ee);
    check({tag, "_busy_at_done"}, obs_busy(nd), 1'b0);
  endtask

  task automatic run_op(input string tag, input int nd, input logic [15:0] av,
                        input logic [15:0] bv, input logic bi);
    logic [15:0] ed;
    logic eb, ee;
    int n;
    model(nd, av, bv, bi, ed, eb, ee);
    if (nd == 4) begin
      a4 = av; b4 = bv; bin4 = bi; start4 = 1'b1;
    end else begin
      a1 = av[3:0]; b1 = bv[3:0]; bin1 = bi; start1 = 1'b1;
    end
    tick();
    start4 = 1'b0; start1 = 1'b0;
    check({tag, "_busy"}, obs_busy(nd), 1'b1);
    wait_done(nd, n);
    check({tag, "_latency"}, n, ee ? 1 : nd + 1);
    check_result(tag, nd, ed, eb, ee);
    tick();
    check({tag, "_done_pulse"}, obs_done(nd), 1'b0);
  endtask

  initial begin
    int n;
    rst_n = 1'b0;
    start4 = 1'b0; a4 = '0; b4 = '0; bin4 = 1'b0;
    start1 = 1'b0; a1 = '0; b1 = '0; bin1 = 1'b0;
    tick();
    tick();
    check("rst_outputs4", {busy4, done4, bout4, err4}, 4'b0);
    check("rst_d4", d4, 16'h0);
    check("rst_outputs1", {busy1, done1, bout1, err1, d1}, 8'h0);
    rst_n = 1'b1;
    tick();

    run_op("basic",   4, 16'h1234, 16'h0567, 1'b0);
    run_op("wrap0",   4, 16'h0000, 16'h0001, 1'b0);
    run_op("wrap9",   4, 16'h9999, 16'h9999, 1'b1);
    run_op("invalid", 4, 16'h12A4, 16'h0001, 1'b0);
    run_op("inv_b",   4, 16'h0005, 16'hF000, 1'b1);

    // Busy rejection, then start held through DONE into IDLE.
    a4 = 16'h1234; b4 = 16'h0567; bin4 = 1'b0; start4 = 1'b1;
    tick();                                   // edge k: accepted
    start4 = 1'b0;
    tick(); tick();                           // k+2
    a4 = 16'h5000; b4 = 16'h0001; start4 = 1'b1;
    tick();                                   // k+3: ignored while busy
    start4 = 1'b0;
    tick();                                   // k+4: last digit, now in DONE
    check("rej_busy_low", busy4, 1'b0);
    start4 = 1'b1;
    tick();                                   // k+5: DONE cycle, start not sampled
    check("rej_done", done4, 1'b1);
    check("rej_busy_done", busy4, 1'b0);
    check("rej_d", d4, 16'h0667);
    check("rej_bout", bout4, 1'b0);
    tick();                                   // k+6: accepted in IDLE
    start4 = 1'b0;
    check("b2b_busy", busy4, 1'b1);
    check("b2b_done_low", done4, 1'b0);
    wait_done(4, n);
    check("b2b_latency", n, 5);
    check("b2b_d", d4, 16'h4999);
    check("b2b_bout", bout4, 1'b0);
    tick();

    // Reset two cycles into RUN abandons the operation.
    a4 = 16'h8765; b4 = 16'h1234; bin4 = 1'b0; start4 = 1'b1;
    tick();
    start4 = 1'b0;
    tick(); tick();
    rst_n = 1'b0;
    tick();
    check("midrst_flags", {busy4, done4, bout4, err4}, 4'b0);
    check("midrst_d", d4, 16'h0);
    rst_n = 1'b1;
    tick();
    check("midrst_no_done", done4, 1'b0);
    run_op("after_rst", 4, 16'h8765, 16'h1234, 1'b1);

    for (int i = 0; i < 20; i++)
      run_op("sweep4", 4, rand_bcd(4), rand_bcd(4), 1'($urandom_range(0, 1)));
    for (int i = 0; i < 20; i++)
      run_op("sweep1", 1, rand_bcd(1), rand_bcd(1), 1'($urandom_range(0, 1)));
    run_op("inv1", 1, 16'h000C, 16'h0003, 1'b0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
